// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core and the multiply/divide unit.
interface muldiv_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, mthi, mtlo, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, mthi, mtlo, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle shift-add multiplier / restoring divider owning HI/LO.
module muldiv_unit #(
  parameter int ITER = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [63:0]    p;      // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [31:0]    d;      // mult: multiplicand magnitude; div: divisor magnitude
  logic           sa, sb, is_div, dz;
  logic           busy_q, done_q;
  logic [31:0]    hi_q, lo_q;

  // operand magnitudes; op[0]==0 selects the signed variants
  logic        sgn_op;
  logic [31:0] amag, bmag;
  assign sgn_op = ~bus.op[0];
  assign amag   = (sgn_op & bus.a[31]) ? -bus.a : bus.a;
  assign bmag   = (sgn_op & bus.b[31]) ? -bus.b : bus.b;

  logic [32:0] madd;
  logic [63:0] mul_step;
  assign madd     = {1'b0, p[63:32]} + {1'b0, (p[0] ? d : 32'h0)};
  assign mul_step = {madd, p[31:1]};

  logic [32:0] dtry, dsub;
  logic        ge;
  logic [63:0] div_step;
  assign dtry     = {p[63:32], p[31]};
  assign dsub     = dtry - {1'b0, d};
  assign ge       = ~dsub[32];
  assign div_step = {(ge ? dsub[31:0] : dtry[31:0]), p[30:0], ge};

  // sign correction applied once at the end; divide-by-zero forces an all-ones quotient
  logic [63:0] prod_s;
  logic [31:0] q_s, r_s, res_hi, res_lo;
  assign prod_s = (sa ^ sb) ? -p : p;
  assign q_s    = (sa ^ sb) ? -p[31:0] : p[31:0];
  assign r_s    = sa ? -p[63:32] : p[63:32];
  assign res_hi = is_div ? r_s : prod_s[63:32];
  assign res_lo = is_div ? (dz ? 32'hFFFF_FFFF : q_s) : prod_s[31:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      p      <= '0;
      d      <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      is_div <= 1'b0;
      dz     <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa     <= sgn_op & bus.a[31];
            sb     <= sgn_op & bus.b[31];
            is_div <= bus.op[1];
            dz     <= bus.op[1] & (bus.b == 32'h0);
            p      <= {32'h0, (bus.op[1] ? amag : bmag)};
            d      <= bus.op[1] ? bmag : amag;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            if (bus.mthi) hi_q <= bus.a;
            if (bus.mtlo) lo_q <= bus.a;
          end
        end
        RUN: begin
          p   <= is_div ? div_step : mul_step;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) state <= FIX;
        end
        FIX: begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit: table of ops plus corner sequences.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_unit_if mif ();
  muldiv_unit #(.ITER(32)) dut (.clk(clk), .rst(rst), .bus(mif));

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  localparam logic [1:0] MULT = 2'd0, MULTU = 2'd1, DIV = 2'd2, DIVU = 2'd3;

  vec_t tbl [11];
  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input logic [31:0] phi, input logic [31:0] plo);
    int n;
    @(negedge clk);
    mif.start = 1'b1; mif.op = op; mif.a = a; mif.b = b;
    @(negedge clk);
    // scramble operands after E0; they must have been latched
    mif.start = 1'b0; mif.op = ~op; mif.a = 32'h5A5A_5A5A; mif.b = 32'h0;
    n = 0;
    while (mif.busy && n < 40) begin
      n++;
      if (n == 16) begin
        chk("hold_hi", mif.hi, phi);
        chk("hold_lo", mif.lo, plo);
      end
      @(negedge clk);
    end
    chk("busy_cycles", 32'(n), 32'd33);
    chk("done_pulse", {31'h0, mif.done}, 32'd1);
    chk("hi", mif.hi, ehi);
    chk("lo", mif.lo, elo);
    @(negedge clk);
    chk("done_drop", {31'h0, mif.done}, 32'd0);
  endtask

  initial begin
    logic [31:0] phi, plo;
    int n;

    tbl[0]  = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[1]  = '{MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    tbl[2]  = '{MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    tbl[3]  = '{DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
    tbl[4]  = '{DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[5]  = '{DIV,   32'h0000_000C, 32'h0000_0000, 32'h0000_000C, 32'hFFFF_FFFF};
    tbl[6]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tbl[7]  = '{DIVU,  32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[8]  = '{DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    tbl[9]  = '{DIV,   32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF};
    tbl[10] = '{MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};

    mif.start = 1'b0; mif.op = 2'd0; mif.a = '0; mif.b = '0;
    mif.mthi = 1'b0; mif.mtlo = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'h0, mif.busy}, 32'd0);
    chk("rst_done", {31'h0, mif.done}, 32'd0);
    chk("rst_hi", mif.hi, 32'h0);
    chk("rst_lo", mif.lo, 32'h0);

    phi = 32'h0; plo = 32'h0;
    for (int i = 0; i < 11; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, phi, plo);
      phi = tbl[i].hi; plo = tbl[i].lo;
    end

    // start and mthi arriving while busy must both be dropped
    @(negedge clk);
    mif.start = 1'b1; mif.op = MULTU; mif.a = 32'd2; mif.b = 32'd3;
    @(negedge clk);
    mif.start = 1'b0;
    repeat (9) @(negedge clk);
    mif.start = 1'b1; mif.op = DIVU; mif.mthi = 1'b1; mif.a = 32'hDEAD_BEEF; mif.b = 32'd1;
    @(negedge clk);
    mif.start = 1'b0; mif.mthi = 1'b0;
    n = 0;
    while (mif.busy && n < 40) begin n++; @(negedge clk); end
    chk("rej_busy_end", {31'h0, mif.busy}, 32'd0);
    chk("rej_done", {31'h0, mif.done}, 32'd1);
    chk("rej_hi", mif.hi, 32'h0);
    chk("rej_lo", mif.lo, 32'h6);
    repeat (3) @(negedge clk);
    chk("rej_no_restart", {31'h0, mif.busy}, 32'd0);

    // register moves in IDLE
    mif.mthi = 1'b1; mif.a = 32'h1234_5678;
    @(negedge clk);
    mif.mthi = 1'b0;
    chk("mthi_hi", mif.hi, 32'h1234_5678);
    chk("mthi_lo", mif.lo, 32'h6);
    chk("mthi_busy", {31'h0, mif.busy}, 32'd0);
    chk("mthi_done", {31'h0, mif.done}, 32'd0);
    mif.mthi = 1'b1; mif.mtlo = 1'b1; mif.a = 32'hCAFE_F00D;
    @(negedge clk);
    mif.mthi = 1'b0; mif.mtlo = 1'b0;
    chk("mvboth_hi", mif.hi, 32'hCAFE_F00D);
    chk("mvboth_lo", mif.lo, 32'hCAFE_F00D);
    chk("mvboth_done", {31'h0, mif.done}, 32'd0);

    // start together with a move: start wins
    mif.start = 1'b1; mif.mtlo = 1'b1; mif.op = DIVU; mif.a = 32'd100; mif.b = 32'd7;
    @(negedge clk);
    mif.start = 1'b0; mif.mtlo = 1'b0;
    chk("startprio_lo", mif.lo, 32'hCAFE_F00D);
    chk("startprio_busy", {31'h0, mif.busy}, 32'd1);

    // reset in the middle of that divide
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_hi", mif.hi, 32'h0);
    chk("midrst_lo", mif.lo, 32'h0);
    chk("midrst_busy", {31'h0, mif.busy}, 32'd0);
    chk("midrst_done", {31'h0, mif.done}, 32'd0);
    repeat (25) @(negedge clk);
    chk("midrst_no_write", mif.lo, 32'h0);
    chk("midrst_still_idle", {31'h0, mif.busy}, 32'd0);

    run_op(DIVU, 32'd9, 32'd4, 32'd1, 32'd2, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
